// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low glyphs (bit7 = DP,
// bits 6..0 = g..a) and a hex-to-glyph helper for upstream decoders.
package seven_seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_NA    = 8'hFE;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  // Values above 9 have no decimal glyph and map to the "not available" mark.
  function automatic logic [7:0] seg_digit(input logic [3:0] value);
    logic [7:0] glyph;
    case (value)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_NA;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Scan timebase: slot prescaler, digit index and free-running frame counter.
module seven_seg_scan_timer #(
  parameter int N_DIGITS   = 4,
  parameter int PRESCALE_W = 16,
  parameter int BLINK_W    = 6,
  parameter int DIGIT_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic [PRESCALE_W-1:0] cnt,
  output logic [DIGIT_W-1:0]    digit,
  output logic                  slot_end,
  output logic                  frame_end,
  output logic                  blink_phase
);

  localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(N_DIGITS - 1);

  logic [BLINK_W-1:0] frame_cnt;

  assign slot_end    = &cnt;
  assign frame_end   = slot_end && (digit == LAST_DIGIT);
  assign blink_phase = frame_cnt[BLINK_W-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      digit     <= '0;
      frame_cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (slot_end) begin
        digit <= (digit == LAST_DIGIT) ? '0 : digit + 1'b1;
      end
      if (frame_end) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode scanner with double-buffered glyph load,
// PWM brightness, per-digit blink, global enable and an anti-ghost dark cycle.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int PRESCALE_W = 16,
  parameter int BRIGHT_W   = 3,
  parameter int BLINK_W    = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [8*N_DIGITS-1:0] load_segs,
  input  logic [N_DIGITS-1:0]   blink_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  disp_en,
  output logic [7:0]            seven_seg,
  output logic [N_DIGITS-1:0]   anode,
  output logic                  frame_done
);

  localparam int DIGIT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [PRESCALE_W-1:0] cnt;
  logic [DIGIT_W-1:0]    digit;
  logic                  slot_end;
  logic                  frame_end;
  logic                  blink_phase;

  logic [8*N_DIGITS-1:0] active;
  logic [8*N_DIGITS-1:0] pending;
  logic                  pending_full;
  logic                  slot_start;
  logic                  accept;
  logic                  lit;
  logic [7:0]            glyph;

  seven_seg_scan_timer #(
    .N_DIGITS   (N_DIGITS),
    .PRESCALE_W (PRESCALE_W),
    .BLINK_W    (BLINK_W),
    .DIGIT_W    (DIGIT_W)
  ) u_timer (
    .clk         (clk),
    .rstn        (rstn),
    .cnt         (cnt),
    .digit       (digit),
    .slot_end    (slot_end),
    .frame_end   (frame_end),
    .blink_phase (blink_phase)
  );

  // Handshake: a load is accepted on any cycle where load_valid && load_ready.
  // load_ready drops while a load waits in pending and returns after the frame
  // end that promotes it; a source seeing ready=0 must hold load_segs/valid.
  assign load_ready = !pending_full;
  assign accept     = load_valid && load_ready;

  // A load accepted on the frame-end cycle bypasses pending so it is shown
  // starting at slot 0 of the very next frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active       <= {N_DIGITS{SEG_BLANK}};
      pending      <= {N_DIGITS{SEG_BLANK}};
      pending_full <= 1'b0;
    end else if (frame_end) begin
      if (accept) begin
        active <= load_segs;
      end else if (pending_full) begin
        active       <= pending;
        pending_full <= 1'b0;
      end
    end else if (accept) begin
      pending      <= load_segs;
      pending_full <= 1'b1;
    end
  end

  // High exactly while cnt==0: the first cycle of every slot stays dark so the
  // previous digit's segments never bleed onto the next anode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_start <= 1'b1;
    end else begin
      slot_start <= slot_end;
    end
  end

  always_comb begin
    lit = disp_en
       && !slot_start
       && (cnt[PRESCALE_W-1 -: BRIGHT_W] <= brightness)
       && !(blink_en[digit] && blink_phase);
    glyph = active[{digit, 3'b000} +: 8];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seven_seg  <= SEG_BLANK;
      anode      <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (lit) begin
        seven_seg <= glyph;
        anode     <= ~(N_DIGITS'(1) << digit);
      end else begin
        seven_seg <= SEG_BLANK;
        anode     <= '1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan at 4 digits, 16-cycle slots, 64-cycle frames.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_segs = 32'h0;
  logic [3:0]  blink_en = 4'b0000;
  logic [1:0]  brightness = 2'd3;
  logic        disp_en = 1'b1;
  logic [7:0]  seven_seg;
  logic [3:0]  anode;
  logic        frame_done;

  seven_seg_scan #(
    .N_DIGITS   (4),
    .PRESCALE_W (4),
    .BRIGHT_W   (2),
    .BLINK_W    (2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_segs  (load_segs),
    .blink_en   (blink_en),
    .brightness (brightness),
    .disp_en    (disp_en),
    .seven_seg  (seven_seg),
    .anode      (anode),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: predicts the registered outputs for every clock edge.
  logic [12:0] exp_q[$];
  int          m_cnt, m_digit, m_frame;
  logic [31:0] m_active, m_pend;
  logic        m_full, m_lit, m_fe, m_acc;
  logic [7:0]  m_seg;
  logic [3:0]  m_an;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt = 0; m_digit = 0; m_frame = 0;
      m_active = 32'hFFFF_FFFF; m_pend = 32'hFFFF_FFFF; m_full = 1'b0;
      exp_q.delete();
    end else begin
      m_fe  = (m_cnt == 15) && (m_digit == 3);
      m_lit = disp_en && (m_cnt != 0) && ((m_cnt / 4) <= int'(brightness))
              && !(blink_en[m_digit] && (m_frame >= 2));
      m_seg = m_lit ? m_active[8*m_digit +: 8] : 8'hFF;
      m_an  = m_lit ? ~(4'b0001 << m_digit) : 4'hF;
      exp_q.push_back({m_seg, m_an, m_fe});
      m_acc = load_valid && !m_full;
      if (m_fe) begin
        if (m_acc) m_active = load_segs;
        else if (m_full) begin m_active = m_pend; m_full = 1'b0; end
      end else if (m_acc) begin
        m_pend = load_segs; m_full = 1'b1;
      end
      if (m_fe) m_frame = (m_frame + 1) % 4;
      if (m_cnt == 15) m_digit = (m_digit + 1) % 4;
      m_cnt = (m_cnt + 1) % 16;
    end
  end

  logic [12:0] sb_exp;
  always @(negedge clk) begin
    if (!rstn) begin
      check("reset_outputs", {seven_seg, anode, frame_done}, {8'hFF, 4'hF, 1'b0});
      check("reset_ready", load_ready, 1'b1);
    end else if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      check("scoreboard_outputs", {seven_seg, anode, frame_done}, sb_exp);
      check("scoreboard_ready", load_ready, !m_full);
    end
  end

  // cur = frame position of the DUT state that the visible outputs reflect.
  int cur = 0;

  task automatic tick();
    @(negedge clk);
    cur++;
  endtask

  task automatic wait_fd();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    check("frame_done_seen", frame_done, 1'b1);
    cur = -1;
  endtask

  task automatic chk_pos(input int p, input logic [3:0] an, input logic [7:0] seg, input string name);
    while (cur < p) tick();
    check(name, {anode, seven_seg}, {an, seg});
  endtask

  task automatic do_load(input logic [31:0] v);
    logic got;
    got = 1'b0;
    load_segs  = v;
    load_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      got = load_ready;
      tick();
      if (got) break;
    end
    load_valid = 1'b0;
    check("load_accepted", got, 1'b1);
  endtask

  typedef struct {
    logic [1:0] bright;
    int         pos;
    logic [3:0] an;
    logic [7:0] seg;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = '{2'd3, 0,  4'hF, 8'hFF};
    vecs[1]  = '{2'd3, 1,  4'hE, 8'hB0};
    vecs[2]  = '{2'd3, 15, 4'hE, 8'hB0};
    vecs[3]  = '{2'd3, 16, 4'hF, 8'hFF};
    vecs[4]  = '{2'd3, 17, 4'hD, 8'hA4};
    vecs[5]  = '{2'd3, 33, 4'hB, 8'hF9};
    vecs[6]  = '{2'd3, 49, 4'h7, 8'hC0};
    vecs[7]  = '{2'd3, 63, 4'h7, 8'hC0};
    vecs[8]  = '{2'd0, 3,  4'hE, 8'hB0};
    vecs[9]  = '{2'd0, 4,  4'hF, 8'hFF};
    vecs[10] = '{2'd0, 19, 4'hD, 8'hA4};
    vecs[11] = '{2'd1, 7,  4'hE, 8'hB0};
    vecs[12] = '{2'd1, 8,  4'hF, 8'hFF};
    vecs[13] = '{2'd1, 55, 4'h7, 8'hC0};
    vecs[14] = '{2'd2, 12, 4'hF, 8'hFF};

    // Reset and release
    repeat (3) tick();
    check("rst_seg", seven_seg, 8'hFF);
    check("rst_anode", anode, 4'hF);
    check("rst_ready", load_ready, 1'b1);
    check("rst_frame_done", frame_done, 1'b0);
    rstn = 1'b1;

    // Basic scan with four glyphs, then brightness table
    do_load(32'hC0F9_A4B0);
    wait_fd();
    for (int i = 0; i < 15; i++) begin
      brightness = vecs[i].bright;
      wait_fd();
      chk_pos(vecs[i].pos, vecs[i].an, vecs[i].seg, $sformatf("vec%0d", i));
    end

    // Brightness change mid-slot acts on the next cycle
    brightness = 2'd3;
    wait_fd();
    chk_pos(5, 4'hE, 8'hB0, "bright_before_change");
    brightness = 2'd0;
    chk_pos(6, 4'hF, 8'hFF, "bright_after_change");
    brightness = 2'd3;

    // Tearing: mid-frame load waits for the frame boundary
    wait_fd();
    chk_pos(20, 4'hD, 8'hA4, "pre_tear");
    do_load(32'h0000_0000);
    check("ready_low_after_accept", load_ready, 1'b0);
    chk_pos(33, 4'hB, 8'hF9, "old_glyph_kept");
    load_segs  = 32'h9999_9999;
    load_valid = 1'b1;
    for (int i = 0; i < 100 && !load_ready; i++) tick();
    check("ready_back_with_frame_done", {load_ready, frame_done}, 2'b11);
    cur = -1;
    tick();
    load_valid = 1'b0;
    check("held_load_now_pending", load_ready, 1'b0);
    check("new_frame_guard", {anode, seven_seg}, {4'hF, 8'hFF});
    chk_pos(1, 4'hE, 8'h00, "new_glyph_slot0");
    chk_pos(17, 4'hD, 8'h00, "new_glyph_slot1");
    wait_fd();
    chk_pos(1, 4'hE, 8'h99, "held_load_next_frame");

    // Accept on the frame-end cycle goes straight to active
    wait_fd();
    chk_pos(62, 4'h7, 8'hC0 ^ 8'h59, "before_frame_end");
    load_segs  = 32'hF8F8_F8F8;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check("same_cycle_ready", {load_ready, frame_done}, 2'b11);
    cur = -1;
    chk_pos(1, 4'hE, 8'hF8, "same_cycle_slot0");
    check("same_cycle_ready_stays", load_ready, 1'b1);
    chk_pos(33, 4'hB, 8'hF8, "same_cycle_slot2");

    // Reset mid-frame with a load pending
    wait_fd();
    chk_pos(10, 4'hE, 8'hF8, "pre_reset");
    do_load(32'h1234_5678);
    check("pending_before_reset", load_ready, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("midreset_outputs", {seven_seg, anode, frame_done}, {8'hFF, 4'hF, 1'b0});
    check("midreset_ready", load_ready, 1'b1);
    blink_en = 4'b0010;
    tick();
    tick();
    rstn = 1'b1;

    // Blink on digit 1: lit in frames 0,1, dark in frames 2,3
    do_load(32'hC0F9_A4B0);
    wait_fd();
    chk_pos(17, 4'hD, 8'hA4, "blink_frame1_lit");
    wait_fd();
    chk_pos(1, 4'hE, 8'hB0, "blink_other_lit");
    chk_pos(17, 4'hF, 8'hFF, "blink_frame2_dark");
    wait_fd();
    chk_pos(17, 4'hF, 8'hFF, "blink_frame3_dark");
    chk_pos(33, 4'hB, 8'hF9, "blink_frame3_other");
    wait_fd();
    chk_pos(17, 4'hD, 8'hA4, "blink_frame0_lit");

    // Display disable mid-slot; timing keeps going
    chk_pos(20, 4'hD, 8'hA4, "pre_disable");
    disp_en = 1'b0;
    chk_pos(21, 4'hF, 8'hFF, "disable_next_cycle");
    wait_fd();
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (frame_done) break;
    end
    check("frame_period_disabled", n, 64);
    disp_en = 1'b1;
    wait_fd();
    chk_pos(33, 4'hB, 8'hF9, "buffers_kept");

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
